// File: rtl/lmp_matrix_loader_pkg.sv
// Shared definitions for the max-plus LMP loader and engine: matrix geometry,
// the "no edge" encoding, loader state encoding and the packed-element offset helper.
package lmp_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned M          = 4;
  localparam int unsigned DATA_WIDTH = 5;

  localparam logic signed [DATA_WIDTH-1:0] NO_EDGE = '1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } lmp_state_e;

  // Row-major packing with element [0][0] in the MSBs.
  function automatic int unsigned elem_lsb(int unsigned i, int unsigned j,
                                           int unsigned rows = N, int unsigned cols = M,
                                           int unsigned dw = DATA_WIDTH);
    return (rows * cols - 1 - (i * cols + j)) * dw;
  endfunction

endpackage

// File: rtl/lmp_matrix_loader_if.sv
// Serial edge-beat channel feeding the LMP matrix loader (valid/ready handshake).
interface lmp_matrix_loader_if #(
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 5
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [IDX_WIDTH-1:0]  in_src;
  logic [IDX_WIDTH-1:0]  in_dst;
  logic [DATA_WIDTH-2:0] in_wt;
  logic                  in_last;

  modport master (
    output in_valid,
    output in_src,
    output in_dst,
    output in_wt,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_src,
    input  in_dst,
    input  in_wt,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/lmp_matrix_loader.sv
// Collects graph edges over a valid/ready channel into the max-plus loop-delay matrix
// A_1 and releases the downstream LMP engine once the final edge has been written.
module lmp_matrix_loader #(
  parameter int unsigned N           = lmp_pkg::N,
  parameter int unsigned M           = lmp_pkg::M,
  parameter int unsigned DATA_WIDTH  = lmp_pkg::DATA_WIDTH,
  parameter int unsigned IDX_WIDTH   = $clog2(N),
  parameter int unsigned INOUT_WIDTH = N * M * DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = $clog2(N * M + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  lmp_matrix_loader_if.slave     edge_bus,
  output logic [INOUT_WIDTH-1:0] A_1,
  output logic                   mat_valid,
  output logic                   lmp_rst_n,
  output logic [CNT_WIDTH-1:0]   edge_cnt,
  output logic                   err
);

  import lmp_pkg::*;

  typedef logic [DATA_WIDTH-1:0] elem_t;

  localparam elem_t                NoEdge  = '1;
  localparam logic [CNT_WIDTH-1:0] CntMax  = CNT_WIDTH'(N * M);

  lmp_state_e state_q, state_d;

  elem_t mat_q [N][M];
  elem_t mat_d [N][M];

  logic [CNT_WIDTH-1:0] edge_cnt_q;
  logic                 err_q;
  logic                 mat_valid_q;
  logic                 lmp_rst_n_q;

  logic  in_ready;
  logic  accept;
  logic  idx_ok;
  elem_t wt_ext;

  assign in_ready          = (state_q == StLoad);
  assign edge_bus.in_ready = in_ready;

  // start pre-empts any beat presented in the same cycle.
  assign accept = edge_bus.in_valid & in_ready & ~start;
  assign idx_ok = (32'(edge_bus.in_src) < N) && (32'(edge_bus.in_dst) < M);
  assign wt_ext = {1'b0, edge_bus.in_wt};

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StLoad: if (accept && edge_bus.in_last) state_d = StDone;
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-element write enable decoded from src/dst; parallel edges keep the longest delay.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        mat_d[i][j] = mat_q[i][j];
        if (start) begin
          mat_d[i][j] = NoEdge;
        end else if (accept && idx_ok &&
                     (edge_bus.in_src == IDX_WIDTH'(i)) &&
                     (edge_bus.in_dst == IDX_WIDTH'(j))) begin
          if ((mat_q[i][j] == NoEdge) || (edge_bus.in_wt > mat_q[i][j][DATA_WIDTH-2:0])) begin
            mat_d[i][j] = wt_ext;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          mat_q[i][j] <= NoEdge;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) begin
          mat_q[i][j] <= mat_d[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (start) begin
      edge_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      if (edge_cnt_q != CntMax) edge_cnt_q <= edge_cnt_q + 1'b1;
      if (!idx_ok) err_q <= 1'b1;
    end
  end

  // Registered release so the engine sees a clean reset edge after the last write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_valid_q <= 1'b0;
      lmp_rst_n_q <= 1'b0;
    end else begin
      mat_valid_q <= (state_d == StDone);
      lmp_rst_n_q <= (state_d == StDone);
    end
  end

  always_comb begin
    A_1 = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        A_1[elem_lsb(i, j, N, M, DATA_WIDTH) +: DATA_WIDTH] = mat_q[i][j];
      end
    end
  end

  assign mat_valid = mat_valid_q;
  assign lmp_rst_n = lmp_rst_n_q;
  assign edge_cnt  = edge_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lmp_matrix_loader.sv
// Self-checking bench for lmp_matrix_loader: a 4x4 instance driven from a vector table
// with a scoreboard, plus a 3x3 instance for the out-of-range index path.
module tb_lmp_matrix_loader;

  logic clk;
  logic rst_n;
  logic start4;
  logic start3;

  logic [79:0] a4;
  logic        mv4, lr4, err4;
  logic [4:0]  cnt4;

  logic [44:0] a3;
  logic        mv3, lr3, err3;
  logic [3:0]  cnt3;

  lmp_matrix_loader_if #(.IDX_WIDTH(2), .DATA_WIDTH(5)) bus4 ();
  lmp_matrix_loader_if #(.IDX_WIDTH(2), .DATA_WIDTH(5)) bus3 ();

  lmp_matrix_loader dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .edge_bus  (bus4),
    .A_1       (a4),
    .mat_valid (mv4),
    .lmp_rst_n (lr4),
    .edge_cnt  (cnt4),
    .err       (err4)
  );

  lmp_matrix_loader #(.N(3), .M(3), .DATA_WIDTH(5)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start3),
    .edge_bus  (bus3),
    .A_1       (a3),
    .mat_valid (mv3),
    .lmp_rst_n (lr3),
    .edge_cnt  (cnt3),
    .err       (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int grp;
    int src;
    int dst;
    int wt;
    bit last;
    int ev;
    int ec;
  } vec_t;

  typedef struct {
    int i;
    int j;
    int val;
    int cnt;
  } exp_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  exp_t sb [$];
  int   exp_mat [4][4];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] get4(logic [79:0] a, int i, int j);
    return a[(15 - (i * 4 + j)) * 5 +: 5];
  endfunction

  function automatic logic [79:0] pack4();
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(15 - (i * 4 + j)) * 5 +: 5] = 5'(exp_mat[i][j]);
    return r;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_mat[i][j] = -1;
  endtask

  task automatic do_start4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    clear_exp();
    chk("start_matrix", a4, {80{1'b1}});
    chk("start_cnt", cnt4, 0);
    chk("start_mat_valid", mv4, 0);
    chk("start_lmp_rst_n", lr4, 0);
    chk("start_in_ready", bus4.in_ready, 1);
    chk("start_err", err4, 0);
  endtask

  task automatic send4(int s, int d, int w, bit l, int ev, int ec);
    exp_t e;
    bus4.in_src   = 2'(s);
    bus4.in_dst   = 2'(d);
    bus4.in_wt    = 4'(w);
    bus4.in_last  = l;
    bus4.in_valid = 1'b1;
    if (bus4.in_ready) begin
      e = '{i: s, j: d, val: ev, cnt: ec};
      sb.push_back(e);
    end
    tick();
    bus4.in_valid = 1'b0;
    bus4.in_last  = 1'b0;
    exp_mat[s][d] = ev;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: in_ready got 0 expected 1 for beat (%0d,%0d,%0d)", s, d, w);
    end else begin
      e = sb.pop_front();
      chk("elem", get4(a4, e.i, e.j), 5'(e.val));
      chk("edge_cnt", cnt4, e.cnt);
    end
  endtask

  task automatic check_done4(int ec);
    chk("done_matrix", a4, pack4());
    chk("done_mat_valid", mv4, 1);
    chk("done_lmp_rst_n", lr4, 1);
    chk("done_in_ready", bus4.in_ready, 0);
    chk("done_cnt", cnt4, ec);
  endtask

  initial begin
    logic [44:0] e3;
    int          gap;

    vecs[0] = '{0, 0, 1, 3, 0, 3, 1};
    vecs[1] = '{0, 1, 2, 2, 0, 2, 2};
    vecs[2] = '{0, 2, 0, 4, 1, 4, 3};
    vecs[3] = '{1, 1, 1, 5, 0, 5, 1};
    vecs[4] = '{1, 1, 1, 2, 0, 5, 2};
    vecs[5] = '{1, 1, 1, 7, 1, 7, 3};
    vecs[6] = '{2, 3, 3, 15, 1, 15, 1};
    vecs[7] = '{3, 2, 3, 0, 0, 0, 1};
    vecs[8] = '{3, 3, 2, 6, 0, 6, 2};
    vecs[9] = '{3, 3, 2, 1, 1, 6, 3};

    rst_n  = 1'b0;
    start4 = 1'b0;
    start3 = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_src = '0; bus4.in_dst = '0; bus4.in_wt = '0;
    bus4.in_last  = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_src = '0; bus3.in_dst = '0; bus3.in_wt = '0;
    bus3.in_last  = 1'b0;
    clear_exp();

    repeat (2) tick();
    chk("rst_matrix", a4, {80{1'b1}});
    chk("rst_mat_valid", mv4, 0);
    chk("rst_lmp_rst_n", lr4, 0);
    chk("rst_in_ready", bus4.in_ready, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_err", err4, 0);
    rst_n = 1'b1;

    // Beats in IDLE must be ignored.
    bus4.in_valid = 1'b1; bus4.in_src = 2'd0; bus4.in_dst = 2'd0; bus4.in_wt = 4'd7;
    bus4.in_last  = 1'b1;
    repeat (2) tick();
    bus4.in_valid = 1'b0; bus4.in_last = 1'b0;
    chk("idle_matrix", a4, {80{1'b1}});
    chk("idle_cnt", cnt4, 0);
    chk("idle_mat_valid", mv4, 0);

    for (int v = 0; v < NV; v++) begin
      if (v == 0 || vecs[v].grp != vecs[v-1].grp) do_start4();
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus4.in_src = 2'($urandom); bus4.in_dst = 2'($urandom); bus4.in_wt = 4'($urandom);
        tick();
        chk("gap_cnt", cnt4, vecs[v].ec - 1);
      end
      send4(vecs[v].src, vecs[v].dst, vecs[v].wt, vecs[v].last, vecs[v].ev, vecs[v].ec);
      if (vecs[v].last) begin
        check_done4(vecs[v].ec);
        // DONE holds: a presented beat is not accepted.
        bus4.in_valid = 1'b1; bus4.in_src = 2'd0; bus4.in_dst = 2'd3; bus4.in_wt = 4'd9;
        repeat (2) tick();
        bus4.in_valid = 1'b0;
        chk("hold_matrix", a4, pack4());
        chk("hold_cnt", cnt4, vecs[v].ec);
        chk("hold_mat_valid", mv4, 1);
      end
    end

    // Restart mid-load: start wins over a simultaneous beat.
    do_start4();
    send4(0, 1, 3, 0, 3, 1);
    send4(2, 2, 4, 0, 4, 2);
    start4 = 1'b1;
    bus4.in_valid = 1'b1; bus4.in_src = 2'd1; bus4.in_dst = 2'd1; bus4.in_wt = 4'd9;
    tick();
    start4 = 1'b0;
    bus4.in_valid = 1'b0;
    clear_exp();
    chk("restart_matrix", a4, {80{1'b1}});
    chk("restart_cnt", cnt4, 0);
    chk("restart_in_ready", bus4.in_ready, 1);
    send4(0, 0, 1, 1, 1, 1);
    check_done4(1);

    // Edge counter saturates at N*M.
    do_start4();
    for (int k = 0; k < 17; k++) send4(0, 0, 1, 0, 1, (k + 1 > 16) ? 16 : k + 1);
    send4(0, 0, 2, 1, 2, 16);
    check_done4(16);

    // Asynchronous reset between clock edges, from DONE.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_matrix", a4, {80{1'b1}});
    chk("async_mat_valid", mv4, 0);
    chk("async_lmp_rst_n", lr4, 0);
    chk("async_cnt", cnt4, 0);
    chk("async_in_ready", bus4.in_ready, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // 3x3 instance: out-of-range index flags err and leaves the matrix alone.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    bus3.in_valid = 1'b1; bus3.in_src = 2'd3; bus3.in_dst = 2'd0; bus3.in_wt = 4'd5;
    bus3.in_last  = 1'b0;
    tick();
    chk("n3_err", err3, 1);
    chk("n3_matrix", a3, {45{1'b1}});
    chk("n3_cnt", cnt3, 1);
    chk("n3_mat_valid", mv3, 0);
    bus3.in_src = 2'd0; bus3.in_dst = 2'd2; bus3.in_wt = 4'd6; bus3.in_last = 1'b1;
    tick();
    bus3.in_valid = 1'b0; bus3.in_last = 1'b0;
    e3 = {45{1'b1}};
    e3[30 +: 5] = 5'd6;
    chk("n3_write_matrix", a3, e3);
    chk("n3_err_sticky", err3, 1);
    chk("n3_done", mv3, 1);
    chk("n3_cnt2", cnt3, 2);

    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("n3_err_clear", err3, 0);
    bus3.in_valid = 1'b1; bus3.in_src = 2'd1; bus3.in_dst = 2'd3; bus3.in_wt = 4'd4;
    bus3.in_last  = 1'b1;
    tick();
    bus3.in_valid = 1'b0; bus3.in_last = 1'b0;
    chk("n3_bad_last_done", mv3, 1);
    chk("n3_bad_last_err", err3, 1);
    chk("n3_bad_last_matrix", a3, {45{1'b1}});
    chk("n3_bad_last_lmp", lr3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lmp_matrix_loader.md
Name: lmp_matrix_loader

Overview:
- Upstream stage of the max-plus LMP iteration-bound engine.
- Collects dataflow-graph edges serially over a valid/ready handshake and builds the N×M loop-delay matrix A_1 (-1 = no edge).
- When the last edge is accepted it presents the packed matrix, asserts mat_valid, and releases lmp_rst_n so the LMP engine starts computing on a stable matrix.

Parameters:
N, 4, matrix rows (graph nodes)
M, 4, matrix columns (must equal N)
DATA_WIDTH, 5, signed element width; -1 encodes "no edge"
IDX_WIDTH, $clog2(N), node index width
INOUT_WIDTH, N*M*DATA_WIDTH, packed matrix width
CNT_WIDTH, $clog2(N*M+1), edge counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear matrix to all -1 and begin a load
in_valid  in  1  edge beat valid
in_ready  out  1  loader can accept an edge
in_src  in  IDX_WIDTH  source node (row i)
in_dst  in  IDX_WIDTH  destination node (column j)
in_wt  in  DATA_WIDTH-1  unsigned edge delay, 0..2^(DATA_WIDTH-1)-1
in_last  in  1  final edge of this graph
A_1  out  INOUT_WIDTH  packed signed matrix, row-major, element [0][0] in MSBs; [i][j] at offset (N*M-1-(i*M+j))*DATA_WIDTH
mat_valid  out  1  A_1 complete and stable
lmp_rst_n  out  1  registered active-low reset to downstream LMP engine
edge_cnt  out  CNT_WIDTH  accepted edges this load, saturating at N*M
err  out  1  sticky: an accepted beat had an index >= N

Behaviour:
- Reset values:
  - state IDLE
  - every matrix element -1 (all A_1 bits 1)
  - in_ready=0, mat_valid=0, lmp_rst_n=0, edge_cnt=0, err=0
- States:
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1. Beat accepted when in_valid & in_ready. Accepted beat with in_last -> DONE. start -> LOAD (restart).
  - DONE: in_ready=0, mat_valid=1, lmp_rst_n=1. start -> LOAD. DONE is otherwise held indefinitely.
- start (any state):
  - at that edge: all elements <= -1, edge_cnt <= 0, err <= 0, mat_valid <= 0, lmp_rst_n <= 0, state <= LOAD.
  - start beats in the same cycle as in_valid are ignored (in_ready is not yet 1 in IDLE/DONE; in LOAD, start wins and the beat is dropped).
- Edge write, accepted at cycle k, visible on A_1 at k+1:
  - element [src][dst] <= zero-extended wt if current element is -1.
  - otherwise element <= max(current, wt): parallel edges keep the longest delay (max-plus semantics).
  - self-loops (src==dst) are legal and land on the diagonal.
- Edge counter: edge_cnt increments on every accepted beat, including duplicates and invalid-index beats, saturating at N*M.
- Invalid index: src>=N or dst>=N (only possible when N is not a power of 2):
  - matrix unchanged, err <= 1, beat still counts.
  - if in_last is set, the load still completes.
- Completion: last beat accepted at cycle k -> mat_valid=1 and lmp_rst_n=1 from k+1. The final write is already visible at k+1, so the matrix is never released partially written.
- Hold behaviour:
  - A_1 holds its value in IDLE and DONE; it changes only on start or on an accepted beat.
  - in_valid in IDLE/DONE is ignored.
- A load needs at least one beat; there is no zero-edge completion.
- Asynchronous reset mid-load returns to the reset values immediately; the partial matrix is discarded.
- Width: wt is always nonnegative, so the stored element is never negative unless it is -1. The comparison is unsigned on the DATA_WIDTH-1 LSBs once the element is known not to be -1.

Decomposition:
- Shared package lmp_pkg:
  - N, M, DATA_WIDTH, NO_EDGE = -1
  - state encoding (IDLE/LOAD/DONE)
  - packed-index helper function elem_lsb(i,j)
  - also used by the LMP engine for unpacking
- Single module; no sub-module is natural. The matrix storage is a flat register array with per-element write enable decoded from src/dst.

Test Plan:
- Reset then idle -> A_1 all ones (every element -1), mat_valid=0, lmp_rst_n=0, in_ready=0, edge_cnt=0.
- start; edges (0,1,3),(1,2,2),(2,0,4 last) -> next cycle [0][1]=3, [1][2]=2, [2][0]=4, rest -1; mat_valid=1, lmp_rst_n=1, edge_cnt=3; in_ready=0.
- start; edges (1,1,5),(1,1,2),(1,1,7 last) -> [1][1]=7, edge_cnt=3; all other elements -1.
- start; drive in_valid with in_ready toggled and in_valid gaps; edge (3,3,15 last) -> [3][3]=15 (max positive). No beat is accepted while in_ready=0.
- Mid-load: two edges accepted, then start asserted together with in_valid -> matrix all -1, edge_cnt=0, that beat dropped; following (0,0,1 last) -> only [0][0]=1.
- In DONE, assert rst_n low asynchronously between clock edges -> A_1 all -1, mat_valid=0, lmp_rst_n=0 immediately; for the err path, set N=3 and send src=3 -> err=1, matrix unchanged.
